sma_window: RTL and testbench
=============================

# sma_window

Parametrised streaming simple-moving-average engine for the price path. Accepts one unsigned sample per handshake and keeps the last 2^LOG2_DEPTH accepted samples in a circular buffer. It maintains a running sum and emits the registered window average and sum once the window is full. It has valid/ready backpressure, a synchronous flush and selectable rounding, and sits between the feed decoder and the strategy comparator.

## Interface
- WIDTH, 64, sample and average width in bits (unsigned)
- LOG2_DEPTH, 2, log2 of window length; DEPTH = 2^LOG2_DEPTH, legal range 1..8
- ROUND, 0, 0 = truncate average; 1 = round half up

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous window clear
- valid_i  in  1  input sample valid
- data_i  in  WIDTH  input sample
- ready_o  out  1  block can accept a sample this cycle
- valid_o  out  1  data_o/sum_o hold a valid window result
- data_o  out  WIDTH  window average
- sum_o  out  WIDTH+LOG2_DEPTH  window sum
- full_o  out  1  DEPTH samples held since last reset/flush
- ready_i  in  1  downstream accepts result

## Operation
- Accept: the sample is accepted when valid_i && ready_o && !flush_i.
- ready_o = !valid_o || ready_i. This is combinational and there is no bubble under continuous flow.
- Buffer: DEPTH x WIDTH registers with write pointer wr_ptr (LOG2_DEPTH bits), which wraps DEPTH-1 -> 0.
- Fill counter cnt runs 0..DEPTH and saturates at DEPTH. full_o = (cnt == DEPTH).
- On accept, the oldest entry buf[wr_ptr] is replaced by data_i and wr_ptr increments.
- On accept, sum_next = sum + data_i - buf[wr_ptr], computed in WIDTH+LOG2_DEPTH bits with no overflow possible. Empty slots read as 0, so the formula holds during fill.
- Average:
  - ROUND=0: sum >> LOG2_DEPTH.
  - ROUND=1: (sum + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH, using a one-bit-wider intermediate. The result is always < 2^WIDTH.
- Output register: on accept with cnt_next == DEPTH, data_o/sum_o are loaded with the new values and valid_o is set.
  - Accepts during fill (cnt_next < DEPTH) do not set valid_o.
  - If the output was consumed (valid_o && ready_i) and there is no new result, valid_o clears.
- Hold: while valid_o && !ready_i, data_o and sum_o are stable, ready_o = 0 and input is stalled.
- Flush: flush_i clears the buffer, sum, cnt, wr_ptr, valid_o, data_o and sum_o at the next edge.
  - flush_i wins over a simultaneous valid_i; that sample is dropped.
  - flush_i also discards an unconsumed output.
- Reset (reset_i low, any time) asynchronously clears all state:
  - valid_o=0, full_o=0, data_o=0, sum_o=0, buffer and pointers zero.
  - ready_o is therefore 1 after reset.

## Timing
- Latency is 1 cycle. A sample accepted at edge k produces valid_o/data_o after edge k and includes that sample.
- Throughput is 1 sample/cycle when ready_i=1 and full.
- full_o rises after the edge on which the DEPTH-th sample is accepted.
- The first valid_o is on the same cycle that full_o rises.
- cnt stays at DEPTH until flush/reset. Wrap of wr_ptr has no effect on outputs.
- Simultaneous consume and accept: the new result replaces the old and valid_o stays 1.
- Reset deassertion: the first accept is possible on the first edge after reset_i goes high.

## Test plan
- Fill, DEPTH=4, ROUND=0, ready_i=1: send 10,20,30,40.
  - valid_o=0 for the first three.
  - After the 4th: valid_o=1, full_o=1, sum_o=100, data_o=25.
  - Then send 50: sum_o=140, data_o=35.
- Rounding: send 1,2,2,2 (sum 7).
  - ROUND=0 -> data_o=1.
  - ROUND=1 -> data_o=2.
  - Then send 3 (sum 9): data_o=2 in both modes.
- Width extremes: send 4 x 2^64-1.
  - sum_o = 2^66-4, data_o = 2^64-1.
  - Then send 0: sum_o = 3*(2^64-1), data_o = 0xBFFF_FFFF_FFFF_FFFF.
- Backpressure: full window, hold ready_i=0 for 3 cycles with valid_i=1.
  - ready_o=0 and data_o is stable.
  - Raise ready_i: the next sample is accepted that cycle, with no loss or duplication.
- Flush/reset mid-operation:
  - After 2 samples, assert flush_i together with valid_i: the sample is dropped and cnt=0.
  - Then 4 new samples 4,4,4,4 -> data_o=4.
  - Assert reset_i low mid-stream: all outputs 0 immediately, ready_o=1.
- Wrap: DEPTH=2, ROUND=1, send 1..9.
  - data_o after each of samples 2..9 = 2,3,4,5,6,7,8,9.
  - No glitch at the pointer wrap.

Source files
------------

// File: rtl/sma_window_if.sv
// Streaming handshake bundle for sma_window.
// Sample in (valid/ready), result out (valid/ready), window status and flush.
// "slave" is the averaging engine; "master" is whoever feeds it and drains it.
interface sma_window_if #(
  parameter int WIDTH      = 64,
  parameter int LOG2_DEPTH = 2
);

  logic                        flush_i;
  logic                        valid_i;
  logic [WIDTH-1:0]            data_i;
  logic                        ready_o;
  logic                        valid_o;
  logic [WIDTH-1:0]            data_o;
  logic [WIDTH+LOG2_DEPTH-1:0] sum_o;
  logic                        full_o;
  logic                        ready_i;

  modport slave (
    input  flush_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, sum_o, full_o
  );

  modport master (
    output flush_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, sum_o, full_o
  );

endinterface

// File: rtl/sma_window.sv
// Streaming simple-moving-average engine.
// Keeps the last 2^LOG2_DEPTH accepted samples in a circular buffer together
// with a running sum. Once the window is full, every accepted sample produces
// a registered average/sum result with valid/ready backpressure.
module sma_window #(
  parameter int WIDTH      = 64,
  parameter int LOG2_DEPTH = 2,
  parameter int ROUND      = 0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  sma_window_if.slave  bus
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = WIDTH + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  // Rounding is a constant bias added before the shift; zero means truncate.
  localparam logic [SUM_W:0] HALF = (ROUND != 0) ? (SUM_W+1)'(1 << (LOG2_DEPTH - 1))
                                                 : '0;

  logic [WIDTH-1:0]      window_q [DEPTH];
  logic [WIDTH-1:0]      window_d [DEPTH];
  logic [LOG2_DEPTH-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic                  valid_q, valid_d;
  logic [WIDTH-1:0]      dataOut_q, dataOut_d;
  logic [SUM_W-1:0]      sumOut_q, sumOut_d;

  logic                  readyOut;
  logic                  accept;
  logic [WIDTH-1:0]      oldest;
  logic [SUM_W-1:0]      sumNext;
  logic [SUM_W:0]        roundSum;
  logic [WIDTH-1:0]      avgNext;
  logic [CNT_W-1:0]      cntNext;

  // Handshake and arithmetic for the sample being offered this cycle.
  always_comb begin
    readyOut = !valid_q || bus.ready_i;
    accept   = bus.valid_i && readyOut && !bus.flush_i;
    oldest   = window_q[wrPtr_q];
    sumNext  = sum_q + SUM_W'(bus.data_i) - SUM_W'(oldest);
    roundSum = {1'b0, sumNext} + HALF;
    avgNext  = WIDTH'(roundSum >> LOG2_DEPTH);
    cntNext  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
  end

  // Next state: flush wipes everything, otherwise accept updates the window
  // and a full window reloads the result register.
  always_comb begin
    window_d  = window_q;
    wrPtr_d   = wrPtr_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    valid_d   = valid_q;
    dataOut_d = dataOut_q;
    sumOut_d  = sumOut_q;

    if (bus.flush_i) begin
      for (int i = 0; i < DEPTH; i++) window_d[i] = '0;
      wrPtr_d   = '0;
      cnt_d     = '0;
      sum_d     = '0;
      valid_d   = 1'b0;
      dataOut_d = '0;
      sumOut_d  = '0;
    end else begin
      if (accept) begin
        window_d[wrPtr_q] = bus.data_i;
        wrPtr_d           = wrPtr_q + 1'b1;
        cnt_d             = cntNext;
        sum_d             = sumNext;
      end
      if (accept && (cntNext == CNT_FULL)) begin
        valid_d   = 1'b1;
        dataOut_d = avgNext;
        sumOut_d  = sumNext;
      end else if (valid_q && bus.ready_i) begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously when reset_i is low.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < DEPTH; i++) window_q[i] <= '0;
      wrPtr_q   <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
      dataOut_q <= '0;
      sumOut_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) window_q[i] <= window_d[i];
      wrPtr_q   <= wrPtr_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
      dataOut_q <= dataOut_d;
      sumOut_q  <= sumOut_d;
    end
  end

  assign bus.ready_o = readyOut;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = dataOut_q;
  assign bus.sum_o   = sumOut_q;
  assign bus.full_o  = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_sma_window.sv
// Bench for sma_window: three instances (depth 4 truncate, depth 4 round,
// depth 2 round) share one stimulus stream. A queue-based reference model
// predicts every output each cycle; fixed vectors and corner sequences add
// hand-computed expectations.
module tb_sma_window;

  localparam int W = 64;

  logic         clk;
  logic         rstN;
  logic         flush;
  logic         valid;
  logic         readyIn;
  logic [W-1:0] dataIn;

  int vectors;
  int miscompares;

  sma_window_if #(.WIDTH(W), .LOG2_DEPTH(2)) ifA ();
  sma_window_if #(.WIDTH(W), .LOG2_DEPTH(2)) ifB ();
  sma_window_if #(.WIDTH(W), .LOG2_DEPTH(1)) ifC ();

  assign ifA.flush_i = flush;
  assign ifA.valid_i = valid;
  assign ifA.data_i  = dataIn;
  assign ifA.ready_i = readyIn;
  assign ifB.flush_i = flush;
  assign ifB.valid_i = valid;
  assign ifB.data_i  = dataIn;
  assign ifB.ready_i = readyIn;
  assign ifC.flush_i = flush;
  assign ifC.valid_i = valid;
  assign ifC.data_i  = dataIn;
  assign ifC.ready_i = readyIn;

  sma_window #(.WIDTH(W), .LOG2_DEPTH(2), .ROUND(0)) dutA (
    .clk_i   (clk),
    .reset_i (rstN),
    .bus     (ifA.slave)
  );

  sma_window #(.WIDTH(W), .LOG2_DEPTH(2), .ROUND(1)) dutB (
    .clk_i   (clk),
    .reset_i (rstN),
    .bus     (ifB.slave)
  );

  sma_window #(.WIDTH(W), .LOG2_DEPTH(1), .ROUND(1)) dutC (
    .clk_i   (clk),
    .reset_i (rstN),
    .bus     (ifC.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per configuration, the list of samples in the window and
  // the currently presented result.
  int          cfgDepth [3] = '{4, 4, 2};
  int          cfgRound [3] = '{0, 1, 1};
  logic [63:0] win      [3][$];
  logic        mValid   [3];
  logic [63:0] mData    [3];
  logic [79:0] mSum     [3];

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      win[c].delete();
      mValid[c] = 1'b0;
      mData[c]  = '0;
      mSum[c]   = '0;
    end
  endtask

  task automatic modelStep(input logic f, input logic v, input logic [63:0] d, input logic r);
    logic        rdy;
    logic [79:0] total;
    for (int c = 0; c < 3; c++) begin
      rdy = !mValid[c] || r;
      if (f) begin
        win[c].delete();
        mValid[c] = 1'b0;
        mData[c]  = '0;
        mSum[c]   = '0;
      end else if (v && rdy) begin
        win[c].push_back(d);
        if (win[c].size() > cfgDepth[c]) void'(win[c].pop_front());
        if (win[c].size() == cfgDepth[c]) begin
          total = '0;
          for (int i = 0; i < win[c].size(); i++) total = total + 80'(win[c][i]);
          if (cfgRound[c] != 0) total = total + 80'(cfgDepth[c] / 2);
          mSum[c]   = total - ((cfgRound[c] != 0) ? 80'(cfgDepth[c] / 2) : 80'd0);
          mData[c]  = 64'(total / 80'(cfgDepth[c]));
          mValid[c] = 1'b1;
        end else if (mValid[c] && r) begin
          mValid[c] = 1'b0;
        end
      end else if (mValid[c] && r) begin
        mValid[c] = 1'b0;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and step past the edge.
  task automatic applyStimulus(input logic f, input logic v, input logic [63:0] d, input logic r);
    flush   = f;
    valid   = v;
    dataIn  = d;
    readyIn = r;
    modelStep(f, v, d, r);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string tag, input int c, input logic v, input logic [63:0] d,
                          input logic [79:0] s, input logic fu, input logic rd);
    cmp({tag, ".valid"}, 80'(v), 80'(mValid[c]));
    cmp({tag, ".data"},  80'(d), 80'(mData[c]));
    cmp({tag, ".sum"},   s,      mSum[c]);
    cmp({tag, ".full"},  80'(fu), 80'(win[c].size() == cfgDepth[c]));
    cmp({tag, ".ready"}, 80'(rd), 80'(!mValid[c] || readyIn));
  endtask

  task automatic checkOutput();
    checkOne("A", 0, ifA.valid_o, ifA.data_o, 80'(ifA.sum_o), ifA.full_o, ifA.ready_o);
    checkOne("B", 1, ifB.valid_o, ifB.data_o, 80'(ifB.sum_o), ifB.full_o, ifB.ready_o);
    checkOne("C", 2, ifC.valid_o, ifC.data_o, 80'(ifC.sum_o), ifC.full_o, ifC.ready_o);
  endtask

  typedef struct {
    logic        flush;
    logic        valid;
    logic [63:0] data;
    logic        expValid;
    logic        expFull;
    logic [79:0] expSum;
    logic [63:0] expDataA;
    logic [63:0] expDataB;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic f, input logic v, input logic [63:0] d,
                                 input logic ev, input logic ef, input logic [79:0] es,
                                 input logic [63:0] ea, input logic [63:0] eb);
    vec_t t;
    t.flush = f; t.valid = v; t.data = d;
    t.expValid = ev; t.expFull = ef; t.expSum = es;
    t.expDataA = ea; t.expDataB = eb;
    vecs.push_back(t);
  endfunction

  localparam logic [63:0] MAX = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic        rf, rv, rr;
    logic [63:0] rd;
    vectors     = 0;
    miscompares = 0;

    // Fill and slide
    addVec(0, 1, 10, 0, 0, 0,   0,  0);
    addVec(0, 1, 20, 0, 0, 0,   0,  0);
    addVec(0, 1, 30, 0, 0, 0,   0,  0);
    addVec(0, 1, 40, 1, 1, 100, 25, 25);
    addVec(0, 1, 50, 1, 1, 140, 35, 35);
    addVec(1, 1, 99, 0, 0, 0,   0,  0);
    // Rounding
    addVec(0, 1, 1, 0, 0, 0, 0, 0);
    addVec(0, 1, 2, 0, 0, 0, 0, 0);
    addVec(0, 1, 2, 0, 0, 0, 0, 0);
    addVec(0, 1, 2, 1, 1, 7, 1, 2);
    addVec(0, 1, 3, 1, 1, 9, 2, 2);
    addVec(1, 0, 0, 0, 0, 0, 0, 0);
    // Width extremes
    addVec(0, 1, MAX, 0, 0, 0, 0, 0);
    addVec(0, 1, MAX, 0, 0, 0, 0, 0);
    addVec(0, 1, MAX, 0, 0, 0, 0, 0);
    addVec(0, 1, MAX, 1, 1, 80'h3_FFFF_FFFF_FFFF_FFFC, MAX, MAX);
    addVec(0, 1, 0,   1, 1, 80'h2_FFFF_FFFF_FFFF_FFFD,
           64'hBFFF_FFFF_FFFF_FFFF, 64'hBFFF_FFFF_FFFF_FFFF);
    addVec(1, 0, 0, 0, 0, 0, 0, 0);
    // Flush drops a simultaneous sample and restarts the fill
    addVec(0, 1, 5, 0, 0, 0, 0, 0);
    addVec(0, 1, 6, 0, 0, 0, 0, 0);
    addVec(1, 1, 7, 0, 0, 0, 0, 0);
    addVec(0, 1, 4, 0, 0, 0,  0, 0);
    addVec(0, 1, 4, 0, 0, 0,  0, 0);
    addVec(0, 1, 4, 0, 0, 0,  0, 0);
    addVec(0, 1, 4, 1, 1, 16, 4, 4);

    rstN    = 1'b0;
    flush   = 1'b0;
    valid   = 1'b0;
    readyIn = 1'b1;
    dataIn  = '0;
    modelReset();
    #12;
    cmp("reset.readyA", 80'(ifA.ready_o), 80'd1);
    checkOutput();
    #4 rstN = 1'b1;

    $display("[TB] fixed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].flush, vecs[i].valid, vecs[i].data, 1'b1);
      cmp($sformatf("tbl%0d.validA", i), 80'(ifA.valid_o), 80'(vecs[i].expValid));
      cmp($sformatf("tbl%0d.fullA",  i), 80'(ifA.full_o),  80'(vecs[i].expFull));
      cmp($sformatf("tbl%0d.sumA",   i), 80'(ifA.sum_o),   vecs[i].expSum);
      cmp($sformatf("tbl%0d.dataA",  i), 80'(ifA.data_o),  80'(vecs[i].expDataA));
      cmp($sformatf("tbl%0d.dataB",  i), 80'(ifB.data_o),  80'(vecs[i].expDataB));
      checkOutput();
    end

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 100, 0);
      cmp($sformatf("hold%0d.readyA", i), 80'(ifA.ready_o), 80'd0);
      cmp($sformatf("hold%0d.dataA",  i), 80'(ifA.data_o),  80'd4);
      cmp($sformatf("hold%0d.sumA",   i), 80'(ifA.sum_o),   80'd16);
      checkOutput();
    end
    applyStimulus(0, 1, 100, 1);
    cmp("release.dataA", 80'(ifA.data_o), 80'd28);
    cmp("release.sumA",  80'(ifA.sum_o),  80'd112);
    checkOutput();
    applyStimulus(0, 1, 8, 1);
    cmp("next.dataA", 80'(ifA.data_o), 80'd29);
    cmp("next.sumA",  80'(ifA.sum_o),  80'd116);
    checkOutput();
    applyStimulus(0, 0, 0, 1);
    cmp("drain.validA", 80'(ifA.valid_o), 80'd0);
    checkOutput();

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(0, 1, 9, 1);
    #2 rstN = 1'b0;
    #1;
    cmp("areset.validA", 80'(ifA.valid_o), 80'd0);
    cmp("areset.fullA",  80'(ifA.full_o),  80'd0);
    cmp("areset.dataA",  80'(ifA.data_o),  80'd0);
    cmp("areset.sumA",   80'(ifA.sum_o),   80'd0);
    cmp("areset.readyA", 80'(ifA.ready_o), 80'd1);
    modelReset();
    checkOutput();
    #2 rstN = 1'b1;

    $display("[TB] depth-2 wrap");
    applyStimulus(1, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 1, 64'(k), 1);
      cmp($sformatf("wrap%0d.validC", k), 80'(ifC.valid_o), 80'(k >= 2));
      cmp($sformatf("wrap%0d.dataC",  k), 80'(ifC.data_o),  (k >= 2) ? 80'(k) : 80'd0);
      checkOutput();
    end

    $display("[TB] random traffic");
    applyStimulus(1, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      rf = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       rd = MAX;
        1:       rd = '0;
        2:       rd = 64'($urandom_range(0, 15));
        default: rd = {$urandom(), $urandom()};
      endcase
      applyStimulus(rf, rv, rd, rr);
      checkOutput();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
